// File: rtl/net_arb_pkg.sv
// Shared defaults and helpers for the network output arbiter.
package net_arb_pkg;

    localparam int unsigned c_default_msg_nbits   = 44;
    localparam int unsigned c_default_num_credits = 4;

    // Width of a counter that must hold 0..num_credits inclusive.
    function automatic int unsigned credit_cnt_nbits(input int unsigned num_credits);
        return $clog2(num_credits + 1);
    endfunction

endpackage

// File: rtl/net_output_arbiter_if.sv
// Request/response bundle of the network output arbiter.
// master: the arbiter itself; slave: the upstream sources plus downstream buffer.
interface net_output_arbiter_if
    import net_arb_pkg::*;
#(
    parameter int unsigned p_msg_nbits   = c_default_msg_nbits,
    parameter int unsigned p_num_reqs    = 3,
    parameter int unsigned p_num_credits = c_default_num_credits
) ();

    localparam int unsigned c_cnt_nbits = credit_cnt_nbits(p_num_credits);

    logic [p_msg_nbits-1:0] istream_msg [p_num_reqs];
    logic                   istream_val [p_num_reqs];
    logic                   istream_rdy [p_num_reqs];
    logic [p_msg_nbits-1:0] ostream_msg;
    logic                   ostream_val;
    logic                   credit_return;
    logic [c_cnt_nbits-1:0] credits;
    logic [p_num_reqs-1:0]  grant;
    logic                   credit_err;

    modport master (
        input  istream_msg, istream_val, credit_return,
        output istream_rdy, ostream_msg, ostream_val, credits, grant, credit_err
    );

    modport slave (
        output istream_msg, istream_val, credit_return,
        input  istream_rdy, ostream_msg, ostream_val, credits, grant, credit_err
    );

endinterface

// File: rtl/net_rr_arbiter.sv
// Round-robin priority select with a registered priority pointer.
// The pointer only advances when a grant is actually issued.
module net_rr_arbiter #(
    parameter int unsigned p_num_reqs = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [p_num_reqs-1:0] req,
    input  logic                  grant_en,
    output logic [p_num_reqs-1:0] grant
);

    localparam int unsigned c_idx_nbits = (p_num_reqs > 1) ? $clog2(p_num_reqs) : 1;

    logic [c_idx_nbits-1:0] ptr_q, ptr_d;
    logic [c_idx_nbits:0]   sum;
    logic [c_idx_nbits-1:0] idx;
    logic                   found;

    // Search from the pointer upward, wrapping modulo p_num_reqs; first requester wins.
    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int unsigned k = 0; k < p_num_reqs; k++) begin
            sum = {1'b0, ptr_q} + (c_idx_nbits + 1)'(k);
            if (sum >= (c_idx_nbits + 1)'(p_num_reqs)) begin
                sum = sum - (c_idx_nbits + 1)'(p_num_reqs);
            end
            idx = sum[c_idx_nbits-1:0];
            if (!found && req[idx]) begin
                found = 1'b1;
                if (grant_en) begin
                    grant[idx] = 1'b1;
                    ptr_d = (idx == c_idx_nbits'(p_num_reqs - 1)) ? '0
                                                                  : idx + c_idx_nbits'(1);
                end
            end
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/net_output_arbiter.sv
// Credit-based round-robin output arbiter for a network port.
// Optional statistics counters are enabled by defining NET_OUTPUT_ARB_STATS_EN.
module net_output_arbiter
    import net_arb_pkg::*;
#(
    parameter int unsigned p_msg_nbits   = c_default_msg_nbits,
    parameter int unsigned p_num_reqs    = 3,
    parameter int unsigned p_num_credits = c_default_num_credits
) (
    input  logic                 clk,
    input  logic                 reset,
    net_output_arbiter_if.master bus
`ifdef NET_OUTPUT_ARB_STATS_EN
    ,
    output logic [15:0]          grant_count [p_num_reqs],
    output logic [15:0]          stall_count
`endif
);

    localparam int unsigned c_cnt_nbits = credit_cnt_nbits(p_num_credits);
    localparam logic [c_cnt_nbits-1:0] c_full = c_cnt_nbits'(p_num_credits);

    logic [p_num_reqs-1:0]  req_vec;
    logic [p_num_reqs-1:0]  grant_vec;
    logic                   any_req;
    logic                   has_credit;
    logic                   grant_en;
    logic                   send;
    logic [c_cnt_nbits-1:0] credits_q, credits_d;
    logic                   err_q, err_d;

    // Gather valids; grants are suppressed with no credit or while reset is held.
    always_comb begin
        req_vec = '0;
        for (int unsigned i = 0; i < p_num_reqs; i++) begin
            req_vec[i] = bus.istream_val[i];
        end
        any_req    = |req_vec;
        has_credit = (credits_q != '0);
        grant_en   = has_credit & reset;
        send       = grant_en & any_req;
    end

    net_rr_arbiter #(
        .p_num_reqs (p_num_reqs)
    ) u_rr_arbiter (
        .clk      (clk),
        .reset    (reset),
        .req      (req_vec),
        .grant_en (grant_en),
        .grant    (grant_vec)
    );

    // Zero-latency outputs: one-hot OR mux of the winner's message.
    always_comb begin
        bus.ostream_msg = '0;
        for (int unsigned i = 0; i < p_num_reqs; i++) begin
            bus.istream_rdy[i] = grant_vec[i];
            if (grant_vec[i]) begin
                bus.ostream_msg = bus.ostream_msg | bus.istream_msg[i];
            end
        end
        bus.ostream_val = send;
        bus.grant       = grant_vec;
        bus.credits     = credits_q;
        bus.credit_err  = err_q;
    end

    // Credit next-state: send and return cancel; a return at full saturates and flags.
    always_comb begin
        credits_d = credits_q;
        err_d     = err_q;
        case ({send, bus.credit_return})
            2'b10: credits_d = credits_q - c_cnt_nbits'(1);
            2'b01: begin
                if (credits_q == c_full) begin
                    err_d = 1'b1;
                end else begin
                    credits_d = credits_q + c_cnt_nbits'(1);
                end
            end
            default: ;
        endcase
    end

    // Credit counter and sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credits_q <= c_full;
            err_q     <= 1'b0;
        end else begin
            credits_q <= credits_d;
            err_q     <= err_d;
        end
    end

`ifdef NET_OUTPUT_ARB_STATS_EN
    logic [15:0] gc_q [p_num_reqs];
    logic [15:0] stall_q;

    // Saturating per-requester grant counters and credit-stall counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < p_num_reqs; i++) begin
                gc_q[i] <= '0;
            end
            stall_q <= '0;
        end else begin
            for (int unsigned i = 0; i < p_num_reqs; i++) begin
                if (grant_vec[i] && (gc_q[i] != 16'hFFFF)) begin
                    gc_q[i] <= gc_q[i] + 16'd1;
                end
            end
            if (any_req && !has_credit && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    // Drive statistics ports from their registers.
    always_comb begin
        for (int unsigned i = 0; i < p_num_reqs; i++) begin
            grant_count[i] = gc_q[i];
        end
        stall_count = stall_q;
    end
`endif

endmodule

// File: tb/tb_net_output_arbiter.sv
// Self-checking bench for net_output_arbiter: directed scenarios followed by
// random traffic, all checked against a behavioural model of the arbitration rules.
module tb_net_output_arbiter;

    localparam int unsigned N    = 3;
    localparam int unsigned W    = 44;
    localparam int unsigned CRED = 4;

    logic clk;
    logic reset;

    net_output_arbiter_if #(.p_msg_nbits(W), .p_num_reqs(N), .p_num_credits(CRED)) bus ();

`ifdef NET_OUTPUT_ARB_STATS_EN
    logic [15:0] grant_count [N];
    logic [15:0] stall_count;
`endif

    net_output_arbiter #(
        .p_msg_nbits   (W),
        .p_num_reqs    (N),
        .p_num_credits (CRED)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus)
`ifdef NET_OUTPUT_ARB_STATS_EN
        ,
        .grant_count (grant_count),
        .stall_count (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int m_ptr;
    int m_credits;
    bit m_err;
    int m_gc [N];
    int m_stall;

    logic [N-1:0] last_grant;
    logic         last_val;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr     = 0;
        m_credits = CRED;
        m_err     = 0;
        for (int i = 0; i < N; i++) m_gc[i] = 0;
        m_stall   = 0;
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, advance model, move to next cycle.
    task automatic step(input logic [N-1:0] v, input logic cr);
        logic [W-1:0] msg [N];
        logic [N-1:0] rdy;
        logic [N-1:0] exp_grant;
        bit           send;
        int           w;
        for (int i = 0; i < N; i++) begin
            msg[i] = W'({$urandom, $urandom});
            bus.istream_msg[i] = msg[i];
            bus.istream_val[i] = v[i];
        end
        bus.credit_return = cr;
        #2;
        send = (v != '0) && (m_credits > 0);
        w = -1;
        if (send) begin
            for (int k = 0; k < N; k++) begin
                if (w < 0 && v[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
        end
        exp_grant = send ? N'(1 << w) : '0;
        for (int i = 0; i < N; i++) rdy[i] = bus.istream_rdy[i];
        chk("grant", 64'(bus.grant), 64'(exp_grant));
        chk("ostream_val", 64'(bus.ostream_val), 64'(send));
        chk("istream_rdy", 64'(rdy), 64'(exp_grant));
        if (send) chk("ostream_msg", 64'(bus.ostream_msg), 64'(msg[w]));
        chk("credits", 64'(bus.credits), 64'(m_credits));
        chk("credit_err", 64'(bus.credit_err), 64'(m_err));
`ifdef NET_OUTPUT_ARB_STATS_EN
        for (int i = 0; i < N; i++) chk("grant_count", 64'(grant_count[i]), 64'(m_gc[i]));
        chk("stall_count", 64'(stall_count), 64'(m_stall));
`endif
        last_grant = bus.grant;
        last_val   = bus.ostream_val;
        if (v != '0 && m_credits == 0 && m_stall < 16'hFFFF) m_stall++;
        if (send) begin
            if (m_gc[w] < 16'hFFFF) m_gc[w]++;
            m_ptr = (w + 1) % N;
        end
        if (send && !cr) begin
            m_credits--;
        end else if (!send && cr) begin
            if (m_credits == CRED) m_err = 1;
            else m_credits++;
        end
        @(posedge clk);
        #1;
    endtask

    // Assert reset between edges, check immediate effect, release before the next edge.
    task automatic do_reset();
        logic [N-1:0] rdy;
        reset = 1'b0;
        #1;
        for (int i = 0; i < N; i++) rdy[i] = bus.istream_rdy[i];
        chk("rst_ostream_val", 64'(bus.ostream_val), 64'd0);
        chk("rst_grant", 64'(bus.grant), 64'd0);
        chk("rst_rdy", 64'(rdy), 64'd0);
        chk("rst_credits", 64'(bus.credits), 64'(CRED));
        chk("rst_err", 64'(bus.credit_err), 64'd0);
`ifdef NET_OUTPUT_ARB_STATS_EN
        for (int i = 0; i < N; i++) chk("rst_grant_count", 64'(grant_count[i]), 64'd0);
        chk("rst_stall_count", 64'(stall_count), 64'd0);
`endif
        for (int i = 0; i < N; i++) bus.istream_val[i] = 1'b0;
        bus.credit_return = 1'b0;
        model_reset();
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        bus.credit_return = 1'b0;
        for (int i = 0; i < N; i++) begin
            bus.istream_val[i] = 1'b0;
            bus.istream_msg[i] = '0;
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // All valid with a credit return every cycle: strict rotation, credits hold.
        for (int i = 0; i < 6; i++) begin
            step(3'b111, 1'b1);
            chk("rr_seq", 64'(last_grant), 64'(3'b001 << (i % 3)));
        end
        chk("rr_credits_hold", 64'(bus.credits), 64'd4);

        // Single requester drains credits, stalls, then resumes after one return.
        do_reset();
        repeat (4) step(3'b010, 1'b0);
        chk("drain_credits", 64'(bus.credits), 64'd0);
        step(3'b010, 1'b0);
        chk("stall_no_send", 64'(last_val), 64'd0);
        step(3'b010, 1'b1);
        chk("ret_same_cycle_no_send", 64'(last_val), 64'd0);
        chk("ret_credit_one", 64'(bus.credits), 64'd1);
        step(3'b010, 1'b0);
        chk("resume_send", 64'(last_grant), 64'(3'b010));
        chk("resume_credits", 64'(bus.credits), 64'd0);

        // Send and return together at credits=2.
        do_reset();
        step(3'b001, 1'b0);
        step(3'b001, 1'b0);
        chk("pre_cancel_credits", 64'(bus.credits), 64'd2);
        step(3'b100, 1'b1);
        chk("cancel_credits", 64'(bus.credits), 64'd2);

        // Overflow at full credit is sticky until reset.
        do_reset();
        step(3'b000, 1'b1);
        chk("ovf_credits", 64'(bus.credits), 64'd4);
        chk("ovf_err", 64'(bus.credit_err), 64'd1);
        step(3'b111, 1'b0);
        step(3'b111, 1'b0);
        chk("ovf_err_sticky", 64'(bus.credit_err), 64'd1);

        // Reset mid-traffic, then pointer restarts at requester 0.
        step(3'b110, 1'b0);
        for (int i = 0; i < N; i++) bus.istream_val[i] = 1'b1;
        do_reset();
        step(3'b111, 1'b0);
        chk("post_rst_ptr", 64'(last_grant), 64'(3'b001));

        // Random traffic with varying return rates and occasional resets.
        for (int i = 0; i < 600; i++) begin
            logic [N-1:0] v;
            logic         cr;
            v  = N'($urandom_range(0, 7));
            cr = (i < 300) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) == 0) do_reset();
            else step(v, cr);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
